cpu_trace_emitter: RTL and testbench

CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

---
 rtl/cpu_trace_pkg.sv | 53 +++++
 rtl/cpu_trace_bcd.sv | 29 ++
 rtl/cpu_trace_emitter.sv | 160 ++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace emitter: ASCII codes, FSM states,
// record type codes, the timestamp saturation limit and character helpers.
package cpu_trace_pkg;

  localparam logic [7:0] ASCII_CARET  = 8'h5e;  // ^
  localparam logic [7:0] ASCII_AT     = 8'h40;  // @
  localparam logic [7:0] ASCII_COLON  = 8'h3a;  // :
  localparam logic [7:0] ASCII_DOLLAR = 8'h24;  // $
  localparam logic [7:0] ASCII_STAR   = 8'h2a;  // *
  localparam logic [7:0] ASCII_LT     = 8'h3c;  // <
  localparam logic [7:0] ASCII_EQ     = 8'h3d;  // =
  localparam logic [7:0] ASCII_HASH   = 8'h23;  // #
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  // Largest timestamp that still fits in four decimal digits.
  localparam logic [13:0] TIME_SAT = 14'd9999;

  // Word addresses: the two low bits of PC and memory address are dropped.
  localparam logic [31:0] PTR_MASK = 32'hffff_fffc;

  // Each state names the character (or field) being shown on the output.
  typedef enum logic [3:0] {
    ST_IDLE, ST_CARET, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SP0, ST_TAG,
    ST_REG, ST_ADDR, ST_SP1, ST_LT, ST_EQ, ST_SP2, ST_DATA, ST_HASH
  } state_e;

  typedef enum logic {
    TYPE_REG = 1'b0,
    TYPE_MEM = 1'b1
  } rec_type_e;

  // Lowercase hex ASCII for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_ZERO + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

  // ASCII for one BCD digit.
  function automatic logic [7:0] dec_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

  // Nibble idx of a 32-bit word, counted from the most significant end.
  function automatic logic [3:0] hex_nibble(input logic [31:0] v, input logic [2:0] idx);
    return 4'(v >> {3'd7 - idx, 2'b00});
  endfunction

  // BCD digit idx of a packed 4-digit value, counted from the least significant end.
  function automatic logic [3:0] bcd_digit(input logic [15:0] bcd, input logic [2:0] idx);
    return 4'(bcd >> {idx, 2'b00});
  endfunction

endpackage

// File: rtl/cpu_trace_bcd.sv
// Combinational binary-to-BCD converter (double-dabble) for values up to 9999,
// plus the number of significant decimal digits (at least one).
module cpu_trace_bcd (
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic [2:0]  n_digits
);

  // Shift-and-add-3: correct every digit that would overflow on the next shift.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int k = 0; k < 4; k++) begin
        if (bcd[4*k +: 4] >= 4'd5) bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
  end

  // Digit count ignores leading zeros; zero itself prints as one digit.
  always_comb begin
    if (bcd[15:12] != 4'd0)     n_digits = 3'd4;
    else if (bcd[11:8] != 4'd0) n_digits = 3'd3;
    else if (bcd[7:4] != 4'd0)  n_digits = 3'd2;
    else                        n_digits = 3'd1;
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one register-write or memory-write trace record into an ASCII
// frame, one character per clock, e.g. "^12@00003004: $5 <= 0000abcd#".
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_type,
  input  logic [13:0] req_time,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_grf,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        frame_done
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  rec_type_e   type_q, type_d;
  logic [15:0] t_bcd_q, t_bcd_d, r_bcd_q, r_bcd_d;
  logic [2:0]  t_n_q, t_n_d, r_n_q, r_n_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d;
  logic        frame_done_q, frame_done_d;

  logic        accept;
  logic [13:0] time_sat;
  logic [15:0] t_bcd_new, r_bcd_new;
  logic [2:0]  t_n_new, r_n_new;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign time_sat = (req_time > TIME_SAT) ? TIME_SAT : req_time;

  cpu_trace_bcd u_time_bcd (
    .bin      (time_sat),
    .bcd      (t_bcd_new),
    .n_digits (t_n_new)
  );

  cpu_trace_bcd u_grf_bcd (
    .bin      ({9'd0, req_grf}),
    .bcd      (r_bcd_new),
    .n_digits (r_n_new)
  );

  // Capture all record fields (already converted) on acceptance only.
  always_comb begin
    type_d  = type_q;
    t_bcd_d = t_bcd_q;
    t_n_d   = t_n_q;
    r_bcd_d = r_bcd_q;
    r_n_d   = r_n_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      type_d  = rec_type_e'(req_type);
      t_bcd_d = t_bcd_new;
      t_n_d   = t_n_new;
      r_bcd_d = r_bcd_new;
      r_n_d   = r_n_new;
      pc_d    = req_pc & PTR_MASK;
      addr_d  = req_addr & PTR_MASK;
      data_d  = req_data;
    end
  end

  // Frame sequencer; the digit counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 3'd1;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CARET;
      ST_CARET: state_d = ST_TIME;
      ST_TIME:  if (cnt_q == t_n_q - 3'd1) state_d = ST_AT;
      ST_AT:    state_d = ST_PC;
      ST_PC:    if (cnt_q == 3'd7) state_d = ST_COLON;
      ST_COLON: state_d = ST_SP0;
      ST_SP0:   state_d = ST_TAG;
      ST_TAG:   state_d = (type_q == TYPE_REG) ? ST_REG : ST_ADDR;
      ST_REG:   if (cnt_q == r_n_q - 3'd1) state_d = ST_SP1;
      ST_ADDR:  if (cnt_q == 3'd7) state_d = ST_SP1;
      ST_SP1:   state_d = ST_LT;
      ST_LT:    state_d = ST_EQ;
      ST_EQ:    state_d = ST_SP2;
      ST_SP2:   state_d = ST_DATA;
      ST_DATA:  if (cnt_q == 3'd7) state_d = ST_HASH;
      ST_HASH:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
  end

  // Character for the coming cycle, looked up from the next state so the outputs can be flopped.
  always_comb begin
    char_d       = 8'h00;
    char_valid_d = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_HASH);
    case (state_d)
      ST_CARET: char_d = ASCII_CARET;
      ST_TIME:  char_d = dec_ascii(bcd_digit(t_bcd_d, t_n_d - 3'd1 - cnt_d));
      ST_AT:    char_d = ASCII_AT;
      ST_PC:    char_d = hex_ascii(hex_nibble(pc_d, cnt_d));
      ST_COLON: char_d = ASCII_COLON;
      ST_SP0:   char_d = ASCII_SPACE;
      ST_TAG:   char_d = (type_d == TYPE_REG) ? ASCII_DOLLAR : ASCII_STAR;
      ST_REG:   char_d = dec_ascii(bcd_digit(r_bcd_d, r_n_d - 3'd1 - cnt_d));
      ST_ADDR:  char_d = hex_ascii(hex_nibble(addr_d, cnt_d));
      ST_SP1:   char_d = ASCII_SPACE;
      ST_LT:    char_d = ASCII_LT;
      ST_EQ:    char_d = ASCII_EQ;
      ST_SP2:   char_d = ASCII_SPACE;
      ST_DATA:  char_d = hex_ascii(hex_nibble(data_d, cnt_d));
      ST_HASH:  char_d = ASCII_HASH;
      default:  char_d = 8'h00;
    endcase
  end

  // Control state and registered outputs, synchronously reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Record field storage.
  always_ff @(posedge clk) begin
    // NOTE: data-only registers carry no reset; they are always reloaded before being shown.
    type_q  <= type_d;
    t_bcd_q <= t_bcd_d;
    t_n_q   <= t_n_d;
    r_bcd_q <= r_bcd_d;
    r_n_q   <= r_n_d;
    pc_q    <= pc_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Self-checking bench for cpu_trace_emitter: a table of directed records with
// hand-written expected frames, plus back-to-back and mid-frame reset sequences.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_type = 1'b0;
  logic [13:0] req_time = '0;
  logic [31:0] req_pc = '0;
  logic [4:0]  req_grf = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        req_ready;
  logic [7:0]  char;
  logic        char_valid;
  logic        frame_done;

  always #5 clk = ~clk;

  cpu_trace_emitter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .req_time   (req_time),
    .req_pc     (req_pc),
    .req_grf    (req_grf),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .char       (char),
    .char_valid (char_valid),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic        typ;
    logic [13:0] t;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  n_cyc;
  } vec_t;

  localparam int NV = 7;
  vec_t  vecs [NV];
  string exp_txt [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\", wanted \"%s\"", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_type  = v.typ;
    req_time  = v.t;
    req_pc    = v.pc;
    req_grf   = v.grf;
    req_addr  = v.addr;
    req_data  = v.data;
    req_valid = 1'b1;
  endtask

  // Scramble every field once the record has been taken; the frame must not change.
  task automatic garble();
    req_type = 1'($urandom);
    req_time = 14'($urandom);
    req_pc   = $urandom;
    req_grf  = 5'($urandom);
    req_addr = $urandom;
    req_data = $urandom;
  endtask

  // Gather characters from the next negedge until char_valid drops (bounded).
  task automatic collect(output string s, output int n_done, output int done_idx,
                         output int ready_hi, output logic [7:0] gap_char, output bit timeout);
    s = "";
    n_done = 0;
    done_idx = -1;
    ready_hi = 0;
    gap_char = 8'h00;
    timeout = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!char_valid) begin
        gap_char = char;
        timeout = 1'b0;
        break;
      end
      s = $sformatf("%s%c", s, char);
      if (frame_done) begin
        n_done++;
        done_idx = i;
      end
      if (req_ready) ready_hi++;
    end
  endtask

  task automatic check_frame(input string tag, input string s, input int n_done, input int done_idx,
                             input int ready_hi, input logic [7:0] gap_char, input bit timeout,
                             input int vi);
    check({tag, " timeout"}, 64'(timeout), 64'd0);
    check_str({tag, " text"}, s, exp_txt[vi]);
    check({tag, " cycles"}, 64'(s.len()), 64'(vecs[vi].n_cyc));
    check({tag, " done count"}, 64'(n_done), 64'd1);
    check({tag, " done pos"}, 64'(done_idx), 64'(int'(vecs[vi].n_cyc) - 1));
    check({tag, " ready busy"}, 64'(ready_hi), 64'd0);
    check({tag, " gap char"}, 64'(gap_char), 64'h00);
  endtask

  // Send one record from an idle negedge and check the whole frame.
  task automatic run_vec(input int vi, input string tag);
    string s;
    int n_done, done_idx, ready_hi;
    logic [7:0] gap_char;
    bit timeout;
    check({tag, " ready idle"}, 64'(req_ready), 64'd1);
    drive(vecs[vi]);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    garble();
    collect(s, n_done, done_idx, ready_hi, gap_char, timeout);
    check_frame(tag, s, n_done, done_idx, ready_hi, gap_char, timeout, vi);
  endtask

  initial begin
    string s;
    int n_done, done_idx, ready_hi, seen_valid, seen_done;
    logic [7:0] gap_char;
    bit timeout;

    vecs[0] = '{typ:1'b0, t:14'd12,    pc:32'h0000_3004, grf:5'd5,  addr:32'h0,         data:32'h0000_abcd, n_cyc:8'd29};
    exp_txt[0] = "^12@00003004: $5 <= 0000abcd#";
    vecs[1] = '{typ:1'b1, t:14'd0,     pc:32'h0000_3000, grf:5'd0,  addr:32'h0000_001f, data:32'hffff_ffff, n_cyc:8'd35};
    exp_txt[1] = "^0@00003000: *0000001c <= ffffffff#";
    vecs[2] = '{typ:1'b0, t:14'd12000, pc:32'h0000_1237, grf:5'd31, addr:32'h0,         data:32'h1234_5678, n_cyc:8'd32};
    exp_txt[2] = "^9999@00001234: $31 <= 12345678#";
    vecs[3] = '{typ:1'b1, t:14'd9999,  pc:32'hdead_beef, grf:5'd7,  addr:32'h8000_0002, data:32'h0000_0000, n_cyc:8'd38};
    exp_txt[3] = "^9999@deadbeec: *80000000 <= 00000000#";
    vecs[4] = '{typ:1'b0, t:14'd100,   pc:32'hffff_fffc, grf:5'd0,  addr:32'h0,         data:32'h0000_0010, n_cyc:8'd30};
    exp_txt[4] = "^100@fffffffc: $0 <= 00000010#";
    vecs[5] = '{typ:1'b0, t:14'd16383, pc:32'h0000_0000, grf:5'd10, addr:32'h0,         data:32'h0000_0001, n_cyc:8'd32};
    exp_txt[5] = "^9999@00000000: $10 <= 00000001#";
    vecs[6] = '{typ:1'b1, t:14'd7,     pc:32'h0000_0040, grf:5'd3,  addr:32'hcafe_f00d, data:32'h0bad_f00d, n_cyc:8'd35};
    exp_txt[6] = "^7@00000040: *cafef00c <= 0badf00d#";

    // Reset state, with a record offered during reset that must be ignored.
    repeat (2) @(negedge clk);
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    check("reset char_valid", 64'(char_valid), 64'd0);
    check("reset char", 64'(char), 64'h00);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("post reset idle", 64'(char_valid), 64'd0);

    // Table of directed records.
    for (int i = 0; i < NV; i++) run_vec(i, $sformatf("vec%0d", i));

    // Back-to-back: req_valid held, second record presented while the first is busy.
    drive(vecs[0]);
    @(posedge clk);
    #1;
    drive(vecs[1]);
    collect(s, n_done, done_idx, ready_hi, gap_char, timeout);
    check_frame("b2b first", s, n_done, done_idx, ready_hi, gap_char, timeout, 0);
    check("b2b gap ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    garble();
    collect(s, n_done, done_idx, ready_hi, gap_char, timeout);
    check_frame("b2b second", s, n_done, done_idx, ready_hi, gap_char, timeout, 1);

    // Reset on the 10th character aborts the frame.
    drive(vecs[2]);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    garble();
    repeat (10) @(negedge clk);
    check("abort 10th char", 64'(char), 64'(exp_txt[2][9]));
    reset = 1'b1;
    @(negedge clk);
    check("abort char_valid", 64'(char_valid), 64'd0);
    check("abort char", 64'(char), 64'h00);
    check("abort frame_done", 64'(frame_done), 64'd0);
    check("abort req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    seen_valid = 0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (char_valid) seen_valid++;
      if (frame_done) seen_done++;
    end
    check("abort quiet chars", 64'(seen_valid), 64'd0);
    check("abort quiet done", 64'(seen_done), 64'd0);
    run_vec(0, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
